// File: rtl/sisc_pkg.sv
// sisc_pkg: fetch FSM state encoding and instruction width shared by the SISC fetch stage
package sisc_pkg;
  localparam int IW = 32;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/sisc_pc.sv
// sisc_pc: AW-bit program counter (clk, async active-low rst_f to RST_PC, inc, load wins with load_val, pc out)
module sisc_pc #(
  parameter int AW = 16,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) pc <= RST_PC;
    else pc <= load ? load_val : inc ? pc + AW'(1) : pc;
endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction fetch (clk, rst_f; im_addr/im_req/im_ack/im_data memory handshake; ir/ir_valid/ir_take/br_taken/br_addr/halt to control; pc_out, halted, fetch_cnt status)
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int AW = 16,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_f,
  output logic [AW-1:0] im_addr,
  output logic          im_req,
  input  logic          im_ack,
  input  logic [IW-1:0] im_data,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_take,
  input  logic          br_taken,
  input  logic [AW-1:0] br_addr,
  input  logic          halt,
  output logic [AW-1:0] pc_out,
  output logic          halted,
  output logic [31:0]   fetch_cnt
);
  fetch_state_t state, nxt;
  logic acc, take;
  assign acc = state == REQ && im_ack;
  assign take = state == HOLD && ir_take;
  assign im_req = state == REQ;
  assign ir_valid = state == HOLD;
  assign halted = state == HALT;
  assign im_addr = pc_out;
  sisc_pc #(.AW(AW), .RST_PC(RST_PC)) u_pc (
    .clk(clk),
    .rst_f(rst_f),
    .inc(acc),
    .load(take && !halt && br_taken),
    .load_val(br_addr),
    .pc(pc_out)
  );
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? REQ :
          state == REQ  ? (im_ack ? HOLD : REQ) :
          state == HOLD ? (ir_take ? (halt ? HALT : REQ) : HOLD) : HALT;
  end
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) begin
      ir <= '0;
      fetch_cnt <= '0;
    end else if (acc) begin
      ir <= im_data;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: directed self-checking bench for sisc_fetch
module tb_sisc_fetch;
  logic clk = 0, rst_f = 0;
  logic [15:0] im_addr, br_addr = '0, pc_out;
  logic im_req, im_ack = 0, ir_valid, ir_take = 0, br_taken = 0, halt = 0, halted;
  logic [31:0] im_data = '0, ir, fetch_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sisc_fetch #(.AW(16), .RST_PC(16'h0000)) dut (
    .clk(clk), .rst_f(rst_f), .im_addr(im_addr), .im_req(im_req), .im_ack(im_ack),
    .im_data(im_data), .ir(ir), .ir_valid(ir_valid), .ir_take(ir_take),
    .br_taken(br_taken), .br_addr(br_addr), .halt(halt), .pc_out(pc_out),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(im_req), 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_vld"}, 32'(ir_valid), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_cnt"}, fetch_cnt, 0);
    chk({tag, "_pc"}, 32'(pc_out), 0);
  endtask
  initial begin
    #2 chk_reset("rst");
    cyc();
    rst_f = 1;
    cyc();
    chk("t1_req", 32'(im_req), 1);
    chk("t1_addr", 32'(im_addr), 32'h0);
    im_ack = 1; im_data = 32'h1000_0001;
    cyc();
    im_ack = 0;
    chk("t1_ir", ir, 32'h1000_0001);
    chk("t1_vld", 32'(ir_valid), 1);
    chk("t1_pc", 32'(pc_out), 1);
    chk("t1_cnt", fetch_cnt, 1);
    chk("t1_req_off", 32'(im_req), 0);
    cyc();
    chk("hold_vld", 32'(ir_valid), 1);
    ir_take = 1;
    cyc();
    ir_take = 0;
    chk("t2_vld", 32'(ir_valid), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", 32'(im_req), 1);
      chk("t2_addr", 32'(im_addr), 1);
      chk("t2_cnt", fetch_cnt, 1);
      if (i == 3) begin im_ack = 1; im_data = 32'h2222_0002; end
      cyc();
    end
    im_ack = 0;
    chk("t2_cnt_inc", fetch_cnt, 2);
    chk("t2_ir", ir, 32'h2222_0002);
    chk("t2_pc", 32'(pc_out), 2);
    ir_take = 1; br_taken = 1; br_addr = 16'h0040;
    cyc();
    ir_take = 0; br_taken = 0;
    chk("t3_req", 32'(im_req), 1);
    chk("t3_addr", 32'(im_addr), 32'h0040);
    chk("t3_vld", 32'(ir_valid), 0);
    im_ack = 1; im_data = 32'hAAAA_0003;
    cyc();
    im_ack = 0;
    chk("t3_pc", 32'(pc_out), 32'h0041);
    chk("t3_cnt", fetch_cnt, 3);
    ir_take = 1; br_taken = 1; br_addr = 16'hFFFF;
    cyc();
    chk("t4_addr", 32'(im_addr), 32'hFFFF);
    halt = 1;
    cyc();
    ir_take = 0; br_taken = 0; halt = 0;
    chk("t4_ignore_req", 32'(im_req), 1);
    chk("t4_ignore_addr", 32'(im_addr), 32'hFFFF);
    chk("t4_ignore_halted", 32'(halted), 0);
    im_ack = 1; im_data = 32'h5555_0004;
    cyc();
    im_ack = 0;
    chk("t4_wrap_pc", 32'(pc_out), 32'h0000);
    chk("t4_cnt", fetch_cnt, 4);
    ir_take = 1; halt = 1; br_taken = 1; br_addr = 16'h1234;
    cyc();
    ir_take = 0; halt = 0; br_taken = 0;
    chk("t5_halted", 32'(halted), 1);
    chk("t5_vld", 32'(ir_valid), 0);
    im_ack = 1;
    for (int i = 0; i < 20; i++) begin
      chk("t5_req", 32'(im_req), 0);
      cyc();
    end
    im_ack = 0;
    chk("t5_pc", 32'(pc_out), 32'h0000);
    chk("t5_cnt", fetch_cnt, 4);
    chk("t5_ir", ir, 32'h5555_0004);
    chk("t5_still_halted", 32'(halted), 1);
    rst_f = 0;
    cyc();
    rst_f = 1;
    cyc();
    chk("t6_req", 32'(im_req), 1);
    cyc();
    #2 rst_f = 0;
    #1 chk_reset("t6_async");
    im_ack = 1; im_data = 32'hDEAD_BEEF;
    cyc();
    chk_reset("t6_ack_ignored");
    im_ack = 0;
    rst_f = 1;
    cyc();
    chk("t6_restart_req", 32'(im_req), 1);
    chk("t6_restart_addr", 32'(im_addr), 0);
    im_ack = 1; im_data = 32'h7777_0007;
    cyc();
    im_ack = 0;
    chk("t6_ir", ir, 32'h7777_0007);
    chk("t6_pc", 32'(pc_out), 1);
    chk("t6_cnt", fetch_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
